subtractor_serial: RTL and testbench

SUBTRACTOR_SERIAL -- requirements
Module: subtractor_serial

---
 rtl/subtractor_serial.sv | 105 ++++++++++
 tb/tb_subtractor_serial.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial.sv
// Serial subtractor: computes a - b - bin one DIGIT-wide slice per clock edge.
// One operation at a time, IDLE -> BUSY -> DONE, valid/ready handshake on both sides.
module subtractor_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [IDX_W-1:0] idx_q;
    logic             borrow_q;
    logic             bout_q;
    logic             ovf_q;

    logic [31:0]      base_d;
    logic [DIGIT-1:0] a_slice_d;
    logic [DIGIT-1:0] b_slice_d;
    logic [DIGIT-1:0] slice_d;
    logic             borrow_d;
    logic             ovf_d;

    // Overflow uses the sign-based form, equivalent to borrow-into-MSB XOR borrow-out;
    // it is only meaningful when the slice being processed holds bit WIDTH-1.
    always_comb begin
        base_d    = 32'(idx_q) * 32'(DIGIT);
        a_slice_d = a_q[base_d +: DIGIT];
        b_slice_d = b_q[base_d +: DIGIT];
        {borrow_d, slice_d} = {1'b0, a_slice_d} - {1'b0, b_slice_d} - {{DIGIT{1'b0}}, borrow_q};
        ovf_d = (a_slice_d[DIGIT-1] ^ b_slice_d[DIGIT-1]) & (slice_d[DIGIT-1] ^ a_slice_d[DIGIT-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q[base_d +: DIGIT] <= slice_d;
                    borrow_q                <= borrow_d;
                    idx_q                   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        bout_q  <= borrow_d;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is masked while reset is held so nothing is offered during reset.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial: vector table on a 32/8 instance plus
// hand-written backpressure, mid-operation reset and single-slice (8/8) sequences.
module tb_subtractor_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        inValid, inReady, outValid, outReady, bin, bout, ovf;
    logic [31:0] a, b, diff;

    logic        inValid8, inReady8, outValid8, outReady8, bin8, bout8, ovf8;
    logic [7:0]  a8, b8, diff8;

    int checks   = 0;
    int failures = 0;

    subtractor_serial #(.WIDTH(32), .DIGIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .bin(bin),
        .out_valid(outValid), .out_ready(outReady),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    subtractor_serial #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(outValid8), .out_ready(outReady8),
        .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] expDiff;
        logic        expBout;
        logic        expOvf;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Offers one operand set on the 32-bit instance (called #1 after a rising edge, DUT idle)
    // and waits for out_valid; latency counts edges after the acceptance edge.
    task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn, input logic binIn,
                                 output int latency, output logic sawReadyBusy);
        a = aIn; b = bIn; bin = binIn; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        latency = 0;
        sawReadyBusy = 1'b0;
        while (!outValid && latency < 20) begin
            if (inReady) sawReadyBusy = 1'b1;
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic applyStimulus8(input logic [7:0] aIn, input logic [7:0] bIn, input logic binIn,
                                  output int latency);
        a8 = aIn; b8 = bIn; bin8 = binIn; inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        latency = 0;
        while (!outValid8 && latency < 20) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic releaseResult();
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("out_valid_after_release", outValid, 0);
        checkOutput("in_ready_after_release", inReady, 1);
    endtask

    initial begin
        int          lat;
        logic        sawReady;
        logic        stable;
        logic [31:0] heldDiff;
        logic        heldBout, heldOvf;
        int          validSeen;

        vecs[0] = '{32'd50,         32'd20,         1'b0, 32'd30,         1'b0, 1'b0};
        vecs[1] = '{32'd20,         32'd50,         1'b0, 32'hFFFF_FFE2,  1'b1, 1'b0};
        vecs[2] = '{32'd15,         32'd25,         1'b1, 32'hFFFF_FFF5,  1'b1, 1'b0};
        vecs[3] = '{32'h0000_0100,  32'd1,          1'b0, 32'h0000_00FF,  1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1};
        vecs[6] = '{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0};
        vecs[7] = '{32'h1234_5678,  32'h0102_0304,  1'b0, 32'h1132_5374,  1'b0, 1'b0};

        rst_n = 1'b0;
        inValid = 1'b0; outReady = 1'b0; a = '0; b = '0; bin = 1'b0;
        inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", inReady, 0);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_diff", diff, 0);
        checkOutput("reset_bout", bout, 0);
        checkOutput("reset_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready_after_reset", inReady, 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, lat, sawReady);
            checkOutput($sformatf("vec%0d_latency", i), lat, 4);
            checkOutput($sformatf("vec%0d_in_ready_busy", i), sawReady, 0);
            checkOutput($sformatf("vec%0d_in_ready_done", i), inReady, 0);
            checkOutput($sformatf("vec%0d_diff", i), diff, vecs[i].expDiff);
            checkOutput($sformatf("vec%0d_bout", i), bout, vecs[i].expBout);
            checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].expOvf);
            releaseResult();
            checkOutput($sformatf("vec%0d_diff_retained", i), diff, vecs[i].expDiff);
        end

        // Backpressure: hold the result for 10 cycles while a new request waits.
        applyStimulus(32'h8000_0000, 32'd1, 1'b0, lat, sawReady);
        checkOutput("bp_latency", lat, 4);
        heldDiff = diff; heldBout = bout; heldOvf = ovf;
        a = 32'd1; b = 32'd1; bin = 1'b0; inValid = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!outValid || inReady || diff !== heldDiff || bout !== heldBout || ovf !== heldOvf)
                stable = 1'b0;
        end
        checkOutput("bp_stable", stable, 1);
        checkOutput("bp_diff", diff, 32'h7FFF_FFFF);
        checkOutput("bp_ovf", ovf, 1);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("bp_idle_in_ready", inReady, 1);
        checkOutput("bp_idle_out_valid", outValid, 0);
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("bp_held_accepted", inReady, 0);
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp_held_latency", lat, 4);
        checkOutput("bp_held_diff", diff, 0);
        checkOutput("bp_held_bout", bout, 0);
        releaseResult();

        // Reset after two slices of an operation abandons it.
        a = 32'h1234_5678; b = 32'h1111_1111; bin = 1'b0; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mid_partial_diff", diff, 32'h0000_4567);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_diff", diff, 0);
        checkOutput("mid_reset_out_valid", outValid, 0);
        checkOutput("mid_reset_in_ready", inReady, 0);
        validSeen = 0;
        @(posedge clk); #1;
        if (outValid) validSeen++;
        rst_n = 1'b1;
        #1;
        checkOutput("mid_release_in_ready", inReady, 1);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (outValid) validSeen++;
        end
        checkOutput("mid_no_out_valid", validSeen, 0);
        checkOutput("mid_diff_after", diff, 0);
        applyStimulus(32'd100, 32'd1, 1'b0, lat, sawReady);
        checkOutput("post_reset_latency", lat, 4);
        checkOutput("post_reset_diff", diff, 32'd99);
        releaseResult();

        // Single-slice instance.
        applyStimulus8(8'd0, 8'd0, 1'b0, lat);
        checkOutput("w8_latency", lat, 1);
        checkOutput("w8_diff0", diff8, 0);
        checkOutput("w8_bout0", bout8, 0);
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;
        checkOutput("w8_in_ready", inReady8, 1);
        applyStimulus8(8'd255, 8'd0, 1'b1, lat);
        checkOutput("w8_latency2", lat, 1);
        checkOutput("w8_diff1", diff8, 8'd254);
        checkOutput("w8_bout1", bout8, 0);
        checkOutput("w8_ovf1", ovf8, 0);
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;
        applyStimulus8(8'd0, 8'd1, 1'b0, lat);
        checkOutput("w8_diff2", diff8, 8'd255);
        checkOutput("w8_bout2", bout8, 1);
        checkOutput("w8_ovf2", ovf8, 0);
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
